// File: rtl/vga_pkg.sv
// Timing constants shared with the VGA timing generator, plus the read-owner tag type.
package vga_pkg;

  localparam int unsigned VgaHTotal     = 800;
  localparam int unsigned VgaHActive    = 640;
  localparam int unsigned VgaVTotal     = 525;
  localparam int unsigned VgaVActive    = 480;
  localparam int unsigned VgaPixPerWord = 8;
  localparam int unsigned VgaWpl        = VgaHActive / VgaPixPerWord;

  typedef enum logic {
    OwnDisp = 1'b0,
    OwnHost = 1'b1
  } owner_e;

  // Never returns 0, so derived bit-slices stay legal for tiny values.
  function automatic int unsigned vga_clog2(input int unsigned v);
    return (v <= 1) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/vga_lookahead.sv
// Advances a scan position (x,y) by Lead pixels with horizontal and vertical wrap.
module vga_lookahead
  import vga_pkg::*;
#(
  parameter int unsigned HTotal = VgaHTotal,
  parameter int unsigned VTotal = VgaVTotal,
  parameter int unsigned Lead   = 4
) (
  input  logic [9:0] x_i,
  input  logic [9:0] y_i,
  output logic [9:0] xa_o,
  output logic [9:0] ya_o,
  output logic       wrap_o
);

  logic [10:0] xs;

  always_comb begin
    xs     = {1'b0, x_i} + 11'(Lead);
    xa_o   = xs[9:0];
    ya_o   = y_i;
    wrap_o = 1'b0;
    if (xs >= 11'(HTotal)) begin
      xa_o   = 10'(xs - 11'(HTotal));
      ya_o   = (y_i == 10'(VTotal - 1)) ? 10'd0 : y_i + 10'd1;
      // Only the exact crossing counts, so line_base steps once per line.
      wrap_o = (xs == 11'(HTotal));
    end
  end

endmodule

// File: rtl/vga_vram_arbiter.sv
// Shares one sync-read VRAM between deadline-driven display fetches and a host port.
// Display always wins; each read carries an owner tag so returning data is steered correctly.
module vga_vram_arbiter
  import vga_pkg::*;
#(
  parameter int unsigned HTotal     = VgaHTotal,
  parameter int unsigned HActive    = VgaHActive,
  parameter int unsigned VTotal     = VgaVTotal,
  parameter int unsigned VActive    = VgaVActive,
  parameter int unsigned PixPerWord = VgaPixPerWord,
  parameter int unsigned DataW      = 32,
  parameter int unsigned AddrW      = 16,
  parameter int unsigned FetchLead  = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [9:0]       x_i,
  input  logic [9:0]       y_i,
  output logic [DataW-1:0] pix_word_o,
  output logic             pix_load_o,
  input  logic             host_valid_i,
  output logic             host_ready_o,
  input  logic             host_we_i,
  input  logic [AddrW-1:0] host_addr_i,
  input  logic [DataW-1:0] host_wdata_i,
  output logic             host_rvalid_o,
  output logic [DataW-1:0] host_rdata_o,
  output logic             mem_en_o,
  output logic             mem_we_o,
  output logic [AddrW-1:0] mem_addr_o,
  output logic [DataW-1:0] mem_wdata_o,
  input  logic [DataW-1:0] mem_rdata_i
);

  localparam int unsigned Wpl  = HActive / PixPerWord;
  localparam int unsigned GrpW = vga_clog2(PixPerWord);

  logic [9:0]       xa, ya;
  logic             wrap, due, load;
  logic [AddrW-1:0] line_base_d, line_base_q, fetch_addr;
  logic             mem_en_q, mem_we_q;
  logic [AddrW-1:0] mem_addr_q;
  logic [DataW-1:0] mem_wdata_q;
  owner_e           owner_q, rd_own_q;
  logic             rd_vld_q;
  logic [DataW-1:0] next_word_q, pix_word_q, host_rdata_q;
  logic             host_rvalid_q;

  vga_lookahead #(
    .HTotal(HTotal),
    .VTotal(VTotal),
    .Lead  (FetchLead)
  ) u_lookahead (
    .x_i   (x_i),
    .y_i   (y_i),
    .xa_o  (xa),
    .ya_o  (ya),
    .wrap_o(wrap)
  );

  always_comb begin
    due         = (xa < 10'(HActive)) && (ya < 10'(VActive)) && (xa[GrpW-1:0] == '0);
    line_base_d = line_base_q;
    if (wrap) begin
      line_base_d = (ya == 10'd0) ? '0 : line_base_q + AddrW'(Wpl);
    end
    // On the wrap cycle xa is 0, so the fetch must already use the new line's base.
    fetch_addr = (wrap ? line_base_d : line_base_q) + AddrW'(xa >> GrpW);
  end

  // Load when the pixel after this one starts an active group (including next-line group 0).
  always_comb begin
    if (x_i == 10'(HTotal - 1)) begin
      load = (y_i == 10'(VTotal - 1)) || (y_i + 10'd1 < 10'(VActive));
    end else begin
      load = (x_i + 10'd1 < 10'(HActive)) && (y_i < 10'(VActive)) && (x_i[GrpW-1:0] == '1);
    end
  end

  assign host_ready_o  = host_valid_i && !due && !rst_i;
  assign pix_load_o    = load && !rst_i;
  assign pix_word_o    = pix_word_q;
  assign host_rvalid_o = host_rvalid_q;
  assign host_rdata_o  = host_rdata_q;
  assign mem_en_o      = mem_en_q;
  assign mem_we_o      = mem_we_q;
  assign mem_addr_o    = mem_addr_q;
  assign mem_wdata_o   = mem_wdata_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      line_base_q   <= '0;
      mem_en_q      <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      owner_q       <= OwnDisp;
      rd_own_q      <= OwnDisp;
      rd_vld_q      <= 1'b0;
      next_word_q   <= '0;
      pix_word_q    <= '0;
      host_rdata_q  <= '0;
      host_rvalid_q <= 1'b0;
    end else begin
      line_base_q <= line_base_d;
      mem_en_q    <= due || host_valid_i;
      mem_we_q    <= !due && host_valid_i && host_we_i;
      if (due) begin
        mem_addr_q <= fetch_addr;
        owner_q    <= OwnDisp;
      end else if (host_valid_i) begin
        mem_addr_q  <= host_addr_i;
        mem_wdata_q <= host_wdata_i;
        owner_q     <= OwnHost;
      end
      // Second tag stage lines up with mem_rdata, one cycle after the strobe.
      rd_vld_q      <= mem_en_q && !mem_we_q;
      rd_own_q      <= owner_q;
      host_rvalid_q <= rd_vld_q && (rd_own_q == OwnHost);
      if (rd_vld_q && (rd_own_q == OwnHost)) host_rdata_q <= mem_rdata_i;
      if (rd_vld_q && (rd_own_q == OwnDisp)) next_word_q <= mem_rdata_i;
      if (load) pix_word_q <= next_word_q;
    end
  end

endmodule

// File: tb/tb_vga_vram_arbiter.sv
// Directed bench for vga_vram_arbiter: VRAM model, reference fetch math and scoreboard queues.
module tb_vga_vram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  x, y;
  logic [31:0] pix_word, host_rdata, mem_wdata, mem_rdata, host_wdata;
  logic        pix_load, host_valid, host_ready, host_we, host_rvalid, mem_en, mem_we;
  logic [15:0] host_addr, mem_addr;

  always #5 clk = ~clk;

  vga_vram_arbiter dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .x_i          (x),
    .y_i          (y),
    .pix_word_o   (pix_word),
    .pix_load_o   (pix_load),
    .host_valid_i (host_valid),
    .host_ready_o (host_ready),
    .host_we_i    (host_we),
    .host_addr_i  (host_addr),
    .host_wdata_i (host_wdata),
    .host_rvalid_o(host_rvalid),
    .host_rdata_o (host_rdata),
    .mem_en_o     (mem_en),
    .mem_we_o     (mem_we),
    .mem_addr_o   (mem_addr),
    .mem_wdata_o  (mem_wdata),
    .mem_rdata_i  (mem_rdata)
  );

  logic [31:0] vram   [0:65535];
  logic [31:0] shadow [0:65535];

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) vram[mem_addr] <= mem_wdata;
      else        mem_rdata      <= vram[mem_addr];
    end
  end

  typedef struct packed {
    logic        en;
    logic        we;
    logic [15:0] addr;
    logic [31:0] wdata;
  } mop_t;
  typedef struct {
    logic [31:0] data;
    int          cyc;
  } hexp_t;

  mop_t        mq[$];
  logic [31:0] pq[$];
  hexp_t       hq[$];
  logic [31:0] pw_exp;
  int          vectors = 0, miscompares = 0, cyc = 0, acc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s at x=%0d y=%0d: observed %0h, required %0h", tag, x, y, obs, exp);
    end
  endtask

  function automatic void ahead(input int px, input int py, input int lead,
                                output int ax, output int ay);
    ax = px + lead;
    ay = py;
    if (ax >= 800) begin
      ax -= 800;
      ay = (py + 1) % 525;
    end
  endfunction

  task automatic check_reset_outputs();
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_pix_word", pix_word, 0);
    chk("rst_pix_load", pix_load, 0);
    chk("rst_host_ready", host_ready, 0);
    chk("rst_host_rvalid", host_rvalid, 0);
    chk("rst_host_rdata", host_rdata, 0);
  endtask

  // One pixel clock: check combinational outputs, book expectations, clock, check results.
  task automatic step();
    int   ax, ay, nx, ny;
    logic due, ld;
    mop_t m;
    #1;
    ahead(int'(x), int'(y), 4, ax, ay);
    due = (ax < 640) && (ay < 480) && (ax % 8 == 0);
    ahead(int'(x), int'(y), 1, nx, ny);
    ld = (nx < 640) && (ny < 480) && (nx % 8 == 0);
    chk("host_ready", host_ready, host_valid && !due);
    chk("pix_load", pix_load, ld);
    if (host_ready) acc++;
    m = '0;
    if (due) begin
      m.en   = 1'b1;
      m.addr = 16'(ay * 80 + ax / 8);
      pq.push_back(shadow[m.addr]);
    end else if (host_valid) begin
      m.en   = 1'b1;
      m.we   = host_we;
      m.addr = host_addr;
      if (host_we) begin
        m.wdata           = host_wdata;
        shadow[host_addr] = host_wdata;
      end else begin
        hq.push_back('{data: shadow[host_addr], cyc: cyc + 2});
      end
    end
    mq.push_back(m);
    @(posedge clk);
    #1;
    m = mq.pop_front();
    chk("mem_en", mem_en, m.en);
    if (m.en) begin
      chk("mem_we", mem_we, m.we);
      chk("mem_addr", mem_addr, m.addr);
      if (m.we) chk("mem_wdata", mem_wdata, m.wdata);
    end
    if (ld) pw_exp = (pq.size() > 0) ? pq.pop_front() : 32'd0;
    chk("pix_word", pix_word, pw_exp);
    if (hq.size() > 0 && hq[0].cyc == cyc) begin
      chk("host_rvalid", host_rvalid, 1);
      chk("host_rdata", host_rdata, hq[0].data);
      void'(hq.pop_front());
    end else begin
      chk("host_rvalid_idle", host_rvalid, 0);
    end
    cyc++;
    x = x + 10'd1;
    if (x == 10'd800) begin
      x = 10'd0;
      y = (y == 10'd524) ? 10'd0 : y + 10'd1;
    end
  endtask

  // Runs x=0..15 then skips to the end-of-line fetch window, keeping line_base in step.
  task automatic short_line();
    repeat (16) step();
    x = 10'd790;
    repeat (10) step();
  endtask

  initial begin
    for (int n = 0; n < 65536; n++) begin
      vram[n]   = 32'(n);
      shadow[n] = 32'(n);
    end
    rst = 1'b1;
    x = '0; y = '0;
    host_valid = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
    pw_exp = '0;
    acc = 0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs();
    rst = 1'b0;

    // Line 0 in full: fetches at x=8k-4, strobes at 8k-3, group 0 delivers 0.
    repeat (800) step();

    // Rest of frame, with a held host request over x=0..15 of line 5.
    while (y != 10'd0) begin
      if (y == 10'd5) begin
        acc = 0;
        host_valid = 1'b1;
        host_we    = 1'b0;
        repeat (16) begin
          host_addr = 16'(1000 + acc);
          step();
        end
        host_valid = 1'b0;
        chk("line5_accepts", acc, 14);
        x = 10'd790;
        repeat (10) step();
      end else begin
        short_line();
      end
    end

    // Frame 2 line 0 group 0 came from the fetch at x=796 y=524.
    #1;
    chk("f2_l0_w0", pix_word, 32'd0);
    repeat (16) step();

    // Host write then read in blanking.
    x = 10'd700;
    host_valid = 1'b1; host_we = 1'b1; host_addr = 16'd100; host_wdata = 32'hDEADBEEF;
    step();
    host_we = 1'b0;
    step();
    host_valid = 1'b0;
    repeat (3) step();
    chk("blank_rdata_hold", host_rdata, 32'hDEADBEEF);
    x = 10'd790;
    repeat (10) step();

    // Host read at x=3 immediately followed by display read at x=4.
    repeat (3) step();
    host_valid = 1'b1; host_we = 1'b0; host_addr = 16'd100;
    step();
    host_valid = 1'b0;
    repeat (12) step();

    // Reset mid-line with a host read in flight.
    x = 10'd299; y = 10'd200;
    host_valid = 1'b1; host_we = 1'b0; host_addr = 16'd5;
    step();
    chk("inflight_mem_en", mem_en, 1);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs();
    mq.delete();
    pq.delete();
    hq.delete();
    pw_exp = '0;
    repeat (2) begin
      @(posedge clk);
      #1;
      chk("rst_hold_rvalid", host_rvalid, 0);
      chk("rst_hold_ready", host_ready, 0);
      chk("rst_hold_mem_en", mem_en, 0);
    end
    host_valid = 1'b0;
    x = '0; y = '0;
    rst = 1'b0;
    repeat (30) step();
    chk("hq_drained", hq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
